// File: rtl/ecc_pkg.sv
// Shared field/curve constants, point types and GF(P) arithmetic helpers.
package ecc_pkg;

    localparam int unsigned W = 16;
    localparam int unsigned P = 65521;
    localparam int unsigned A = 2;

    localparam logic [W-1:0] GX      = 16'h0003;
    localparam logic [W-1:0] GY      = 16'hFFEB;
    localparam logic [W-1:0] INV_EXP = 16'hFFEF;   // P - 2

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         inf;
    } point_t;

    localparam point_t PT_INF = '{x: '0, y: '0, inf: 1'b1};

    // Result of setting up a point op: either finished (triv) or operands for FIN.
    typedef struct packed {
        logic         triv;
        point_t       res;
        logic [W-1:0] x1;
        logic [W-1:0] y1;
        logic [W-1:0] x2;
        logic [W-1:0] num;
        logic [W-1:0] den;
    } op_t;

    typedef enum logic [1:0] {OP_DBL, OP_ADD, OP_SUB} op_kind_e;

    function automatic logic [W-1:0] mod_red(input logic [W-1:0] a);
        return (32'(a) >= P) ? W'(32'(a) - P) : a;
    endfunction

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [31:0] s;
        s = 32'(a) + 32'(b);
        return (s >= P) ? W'(s - P) : W'(s);
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [31:0] s;
        s = 32'(a) + P - 32'(b);
        return (s >= P) ? W'(s - P) : W'(s);
    endfunction

    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        return W'(p % P);
    endfunction

endpackage

// File: rtl/ecc_decrypter_if.sv
// Request/response bundle of the decryption stage.
interface ecc_decrypter_if;
    import ecc_pkg::*;

    logic             start;
    logic [2*W-1:0]   c1;
    logic [2*W-1:0]   c2;
    logic [7:0]       privkey;
    logic             busy;
    logic [W-1:0]     m1;
    logic [W-1:0]     m2;
    logic             m_inf;
    logic             done;

    modport master (output start, c1, c2, privkey, input busy, m1, m2, m_inf, done);
    modport slave  (input start, c1, c2, privkey, output busy, m1, m2, m_inf, done);
endinterface

// File: rtl/ecc_modinv.sv
// Fermat inverse a^(P-2) mod P, one square-and-multiply step per cycle.
module ecc_modinv
    import ecc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] inv
);
    typedef enum logic [1:0] {MI_IDLE, MI_RUN, MI_OUT} mi_state_e;

    mi_state_e    state_q, state_n;
    logic [W-1:0] base_q, base_n, acc_q, acc_n, inv_n, sq;
    logic [3:0]   bit_q, bit_n;
    logic         busy_n, done_n;

    // Next state: the MSB step is folded into the load, the rest run one per cycle.
    always_comb begin
        state_n = state_q;
        base_n  = base_q;
        acc_n   = acc_q;
        bit_n   = bit_q;
        busy_n  = busy;
        done_n  = 1'b0;
        inv_n   = inv;
        sq      = mod_mul(acc_q, acc_q);
        case (state_q)
            MI_IDLE: if (start) begin
                base_n  = mod_red(a);
                acc_n   = INV_EXP[W-1] ? mod_red(a) : W'(1);
                bit_n   = 4'(W - 2);
                busy_n  = 1'b1;
                state_n = MI_RUN;
            end
            MI_RUN: begin
                acc_n = INV_EXP[bit_q] ? mod_mul(sq, base_q) : sq;
                if (bit_q == 4'd0) state_n = MI_OUT;
                else               bit_n   = bit_q - 4'd1;
            end
            MI_OUT: begin
                done_n  = 1'b1;
                inv_n   = acc_q;
                busy_n  = 1'b0;
                state_n = MI_IDLE;
            end
            default: state_n = MI_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MI_IDLE;
            base_q  <= '0;
            acc_q   <= '0;
            bit_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            inv     <= '0;
        end else begin
            state_q <= state_n;
            base_q  <= base_n;
            acc_q   <= acc_n;
            bit_q   <= bit_n;
            busy    <= busy_n;
            done    <= done_n;
            inv     <= inv_n;
        end
    end
endmodule

// File: rtl/ecc_decrypter.sv
// ElGamal-style ECC decryption: M = C2 - d*C1, one point op at a time.
module ecc_decrypter
    import ecc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ecc_decrypter_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_DBL, S_ADDK, S_INV, S_FIN, S_NEXT, S_SUB, S_OUT
    } state_e;

    state_e       state_q, state_n;
    logic [2:0]   idx_q, idx_n;
    logic [7:0]   key_q, key_n;
    point_t       r_q, r_n, c1_q, c1_n, c2_q, c2_n, neg_s, fin_pt;
    op_kind_e     kind_q, kind_n;
    logic [W-1:0] x1_q, x1_n, y1_q, y1_n, x2_q, x2_n, num_q, num_n, den_q, den_n;
    logic         busy_q, busy_n, done_q, done_n, minf_q, minf_n;
    logic [W-1:0] m1_q, m1_n, m2_q, m2_n;
    logic [W-1:0] lam, x3, inv_a_c, inv_val;
    logic         inv_start_c, inv_busy, inv_done;
    op_t          op_c;

    function automatic op_t dbl_setup(input point_t p);
        op_t o;
        o = '0;
        if (p.inf || p.y == '0) begin
            o.triv = 1'b1;
            o.res  = PT_INF;
        end else begin
            o.x1  = p.x;
            o.y1  = p.y;
            o.x2  = p.x;
            o.num = mod_add(mod_mul(W'(3), mod_mul(p.x, p.x)), W'(A));
            o.den = mod_add(p.y, p.y);
        end
        return o;
    endfunction

    function automatic op_t add_setup(input point_t p, input point_t q);
        op_t o;
        o = '0;
        if (p.inf) begin
            o.triv = 1'b1;
            o.res  = q;
        end else if (q.inf) begin
            o.triv = 1'b1;
            o.res  = p;
        end else if (p.x == q.x) begin
            if (p.y != q.y) begin
                o.triv = 1'b1;
                o.res  = PT_INF;
            end else begin
                o = dbl_setup(p);
            end
        end else begin
            o.x1  = p.x;
            o.y1  = p.y;
            o.x2  = q.x;
            o.num = mod_sub(q.y, p.y);
            o.den = mod_sub(q.x, p.x);
        end
        return o;
    endfunction

    ecc_modinv u_modinv (
        .clk   (clk),
        .rst   (rst),
        .start (inv_start_c),
        .a     (inv_a_c),
        .busy  (inv_busy),
        .done  (inv_done),
        .inv   (inv_val)
    );

    // Operand setup for whichever point op the current state requests.
    always_comb begin
        neg_s   = r_q;
        neg_s.y = mod_sub('0, r_q.y);
        case (state_q)
            S_ADDK:  op_c = add_setup(r_q, c1_q);
            S_SUB:   op_c = add_setup(c2_q, neg_s);
            default: op_c = dbl_setup(r_q);
        endcase
    end

    // Chord/tangent completion once the inverse is available.
    always_comb begin
        lam        = mod_mul(num_q, inv_val);
        x3         = mod_sub(mod_sub(mod_mul(lam, lam), x1_q), x2_q);
        fin_pt.x   = x3;
        fin_pt.y   = mod_sub(mod_mul(lam, mod_sub(x1_q, x3)), y1_q);
        fin_pt.inf = 1'b0;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n     = state_q;
        idx_n       = idx_q;
        key_n       = key_q;
        r_n         = r_q;
        c1_n        = c1_q;
        c2_n        = c2_q;
        kind_n      = kind_q;
        x1_n        = x1_q;
        y1_n        = y1_q;
        x2_n        = x2_q;
        num_n       = num_q;
        den_n       = den_q;
        busy_n      = busy_q;
        done_n      = 1'b0;
        m1_n        = m1_q;
        m2_n        = m2_q;
        minf_n      = minf_q;
        inv_start_c = 1'b0;
        inv_a_c     = den_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                c1_n    = '{x: mod_red(bus.c1[2*W-1:W]), y: mod_red(bus.c1[W-1:0]), inf: 1'b0};
                c2_n    = '{x: mod_red(bus.c2[2*W-1:W]), y: mod_red(bus.c2[W-1:0]), inf: 1'b0};
                key_n   = bus.privkey;
                busy_n  = 1'b1;
                state_n = S_LOAD;
            end
            S_LOAD: begin
                idx_n   = 3'd7;
                r_n     = PT_INF;
                state_n = S_DBL;
            end
            S_DBL, S_ADDK, S_SUB: begin
                if (op_c.triv) begin
                    if (state_q == S_SUB) begin
                        m1_n    = op_c.res.inf ? '0 : op_c.res.x;
                        m2_n    = op_c.res.inf ? '0 : op_c.res.y;
                        minf_n  = op_c.res.inf;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = S_OUT;
                    end else begin
                        r_n     = op_c.res;
                        state_n = (state_q == S_DBL && key_q[idx_q]) ? S_ADDK : S_NEXT;
                    end
                end else begin
                    x1_n        = op_c.x1;
                    y1_n        = op_c.y1;
                    x2_n        = op_c.x2;
                    num_n       = op_c.num;
                    den_n       = op_c.den;
                    inv_start_c = 1'b1;
                    inv_a_c     = op_c.den;
                    kind_n      = (state_q == S_DBL)  ? OP_DBL :
                                  (state_q == S_ADDK) ? OP_ADD : OP_SUB;
                    state_n     = S_INV;
                end
            end
            S_INV: begin
                if (inv_done)      state_n     = S_FIN;
                else if (!inv_busy) inv_start_c = 1'b1;   // inverter lost its request: reissue
            end
            S_FIN: begin
                case (kind_q)
                    OP_DBL: begin
                        r_n     = fin_pt;
                        state_n = key_q[idx_q] ? S_ADDK : S_NEXT;
                    end
                    OP_ADD: begin
                        r_n     = fin_pt;
                        state_n = S_NEXT;
                    end
                    default: begin
                        m1_n    = fin_pt.x;
                        m2_n    = fin_pt.y;
                        minf_n  = 1'b0;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = S_OUT;
                    end
                endcase
            end
            S_NEXT: begin
                if (idx_q == 3'd0) begin
                    state_n = S_SUB;
                end else begin
                    idx_n   = idx_q - 3'd1;
                    state_n = S_DBL;
                end
            end
            S_OUT:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            key_q   <= '0;
            r_q     <= PT_INF;
            c1_q    <= '0;
            c2_q    <= '0;
            kind_q  <= OP_DBL;
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            num_q   <= '0;
            den_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            m1_q    <= '0;
            m2_q    <= '0;
            minf_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            key_q   <= key_n;
            r_q     <= r_n;
            c1_q    <= c1_n;
            c2_q    <= c2_n;
            kind_q  <= kind_n;
            x1_q    <= x1_n;
            y1_q    <= y1_n;
            x2_q    <= x2_n;
            num_q   <= num_n;
            den_q   <= den_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            m1_q    <= m1_n;
            m2_q    <= m2_n;
            minf_q  <= minf_n;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.m1    = m1_q;
    assign bus.m2    = m2_q;
    assign bus.m_inf = minf_q;
endmodule

// File: tb/tb_ecc_decrypter.sv
// Randomized bench for ecc_decrypter and ecc_modinv against an integer curve model.
module tb_ecc_decrypter;
    import ecc_pkg::*;

    localparam longint MP = 65521;

    typedef struct packed {
        longint x;
        longint y;
        bit     inf;
    } pt_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ecc_decrypter_if bus ();
    ecc_decrypter dut (.clk(clk), .rst(rst), .bus(bus));

    logic        mi_start;
    logic [15:0] mi_a;
    logic        mi_busy, mi_done;
    logic [15:0] mi_inv;
    ecc_modinv u_inv (.clk(clk), .rst(rst), .start(mi_start), .a(mi_a),
                      .busy(mi_busy), .done(mi_done), .inv(mi_inv));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint minv(input longint a);
        longint t, nt, r, nr, q, tmp;
        if (a == 0) return 0;
        t = 0; nt = 1; r = MP; nr = a;
        while (nr != 0) begin
            q = r / nr;
            tmp = t - q * nt; t = nt; nt = tmp;
            tmp = r - q * nr; r = nr; nr = tmp;
        end
        if (t < 0) t += MP;
        return t;
    endfunction

    function automatic pt_t pinf();
        pt_t p;
        p.x = 0; p.y = 0; p.inf = 1'b1;
        return p;
    endfunction

    function automatic pt_t padd(input pt_t a, input pt_t b);
        pt_t    r;
        longint lam;
        if (a.inf) return b;
        if (b.inf) return a;
        if (a.x == b.x && a.y != b.y) return pinf();
        if (a.x == b.x) begin
            if (a.y == 0) return pinf();
            lam = ((3 * a.x * a.x + 2) % MP) * minv((2 * a.y) % MP) % MP;
        end else begin
            lam = ((b.y - a.y + MP) % MP) * minv((b.x - a.x + MP) % MP) % MP;
        end
        r.inf = 1'b0;
        r.x   = ((lam * lam) % MP + 2 * MP - a.x - b.x) % MP;
        r.y   = ((lam * ((a.x - r.x + MP) % MP)) % MP + MP - a.y) % MP;
        return r;
    endfunction

    function automatic pt_t pmul(input logic [7:0] d, input pt_t p);
        pt_t r;
        r = pinf();
        for (int b = 7; b >= 0; b--) begin
            r = padd(r, r);
            if (d[b]) r = padd(r, p);
        end
        return r;
    endfunction

    function automatic pt_t unpack(input logic [31:0] v);
        pt_t p;
        p.x = longint'(v[31:16]) % MP;
        p.y = longint'(v[15:0]) % MP;
        p.inf = 1'b0;
        return p;
    endfunction

    function automatic logic [31:0] pack(input pt_t p);
        logic [15:0] x, y;
        x = 16'(p.x);
        y = 16'(p.y);
        return {x, y};
    endfunction

    function automatic pt_t decrypt(input logic [31:0] c1, input logic [31:0] c2, input logic [7:0] d);
        pt_t s;
        s = pmul(d, unpack(c1));
        s.y = (MP - s.y) % MP;
        return padd(unpack(c2), s);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic launch(input logic [31:0] a1, input logic [31:0] a2, input logic [7:0] k);
        bus.c1      = a1;
        bus.c2      = a2;
        bus.privkey = k;
        bus.start   = 1'b1;
    endtask

    task automatic wait_done(input bit poke, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (poke && n == 3) begin
                bus.start   = 1'b1;
                bus.c1      = $urandom;
                bus.c2      = $urandom;
                bus.privkey = 8'($urandom);
            end
            if (poke && n == 4) bus.start = 1'b0;
            @(negedge clk);
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    task automatic expect_pt(input string tag, input pt_t e);
        check({tag, "_m1"},   longint'(bus.m1),    e.inf ? 0 : e.x);
        check({tag, "_m2"},   longint'(bus.m2),    e.inf ? 0 : e.y);
        check({tag, "_minf"}, longint'(bus.m_inf), longint'(e.inf));
    endtask

    task automatic run_case(input string tag, input logic [31:0] a1, input logic [31:0] a2,
                            input logic [7:0] k, input bit poke);
        bit ok;
        launch(a1, a2, k);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, longint'(bus.busy), 1);
        wait_done(poke, ok);
        if (ok) expect_pt(tag, decrypt(a1, a2, k));
        @(negedge clk);
        check({tag, "_done_pulse"}, longint'(bus.done), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        pt_t          g, c1p, c2p;
        logic [31:0]  gp, r1, r2;
        logic [7:0]   k;
        logic [15:0]  ia  [4];
        logic [15:0]  iex [4];
        logic [7:0]   rt  [5];
        int           lat, stray;
        bit           ok;

        ia  = '{16'd2, 16'd3, 16'd1, 16'd0};
        iex = '{16'd32761, 16'd43681, 16'd1, 16'd0};
        rt  = '{8'h01, 8'h02, 8'h03, 8'h55, 8'hFF};

        rst = 1'b1;
        bus.start = 1'b0; bus.c1 = '0; bus.c2 = '0; bus.privkey = '0;
        mi_start = 1'b0; mi_a = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",  longint'(bus.busy),  0);
        check("rst_done",  longint'(bus.done),  0);
        check("rst_m1",    longint'(bus.m1),    0);
        check("rst_m2",    longint'(bus.m2),    0);
        check("rst_minf",  longint'(bus.m_inf), 0);
        check("rst_mi_busy", longint'(mi_busy), 0);

        // Standalone inverter: value and 17-cycle latency.
        for (int i = 0; i < 4; i++) begin
            mi_a = ia[i];
            mi_start = 1'b1;
            @(negedge clk);
            mi_start = 1'b0;
            lat = 1;
            while (!mi_done && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("inv_lat_%0d", ia[i]), lat, 17);
            check($sformatf("inv_val_%0d", ia[i]), longint'(mi_inv), longint'(iex[i]));
            check($sformatf("inv_model_%0d", ia[i]), longint'(mi_inv), minv(longint'(ia[i])));
        end

        g.x = longint'(GX); g.y = longint'(GY); g.inf = 1'b0;
        gp = {GX, GY};

        // privkey = 0: plaintext is C2 itself.
        run_case("key0", $urandom, gp, 8'h00, 1'b0);
        check("key0_const_m1", longint'(bus.m1), 3);
        check("key0_const_m2", longint'(bus.m2), 65515);

        // privkey = 1 with C1 = C2 gives the point at infinity.
        run_case("key1_inf", gp, gp, 8'h01, 1'b0);
        check("key1_inf_const", longint'(bus.m_inf), 1);

        // Round trips: M = G, k = 2.
        c1p = pmul(8'd2, g);
        for (int i = 0; i < 5; i++) begin
            c2p = padd(g, pmul(rt[i], c1p));
            run_case($sformatf("rt_%02x", rt[i]), pack(c1p), pack(c2p), rt[i], 1'b0);
            check($sformatf("rt_%02x_x", rt[i]), longint'(bus.m1), 3);
            check($sformatf("rt_%02x_y", rt[i]), longint'(bus.m2), 65515);
            check($sformatf("rt_%02x_inf", rt[i]), longint'(bus.m_inf), 0);
        end

        // Random ciphertexts and keys; some runs get a start pulse while busy.
        for (int i = 0; i < 10; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            if (i == 2) r1 = 32'hFFFF_FFF5;
            if (i == 3) r2 = {16'hFFF1, 16'h0007};
            k = 8'($urandom);
            run_case($sformatf("rnd%0d", i), r1, r2, k, i[0]);
        end

        // Start presented in the done cycle is accepted one cycle later.
        r1 = $urandom; r2 = $urandom; k = 8'($urandom);
        launch(r1, r2, k);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(1'b0, ok);
        if (ok) expect_pt("chainA", decrypt(r1, r2, k));
        c2p = padd(g, pmul(8'h33, c1p));
        launch(pack(c1p), pack(c2p), 8'h33);
        @(negedge clk);
        check("chain_ignored_busy", longint'(bus.busy), 0);
        check("chain_ignored_done", longint'(bus.done), 0);
        @(negedge clk);
        bus.start = 1'b0;
        check("chain_accept_busy", longint'(bus.busy), 1);
        wait_done(1'b0, ok);
        if (ok) expect_pt("chainB", g);
        @(negedge clk);

        // Reset while the inverter is running on a privkey = 0xFF job.
        c2p = padd(g, pmul(8'hFF, c1p));
        launch(pack(c1p), pack(c2p), 8'hFF);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", longint'(bus.busy),  0);
        check("midrst_done", longint'(bus.done),  0);
        check("midrst_m1",   longint'(bus.m1),    0);
        check("midrst_minf", longint'(bus.m_inf), 0);
        stray = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done || bus.busy) stray++;
        end
        check("midrst_quiet", stray, 0);
        run_case("after_rst", pack(c1p), pack(c2p), 8'hFF, 1'b0);
        check("after_rst_x", longint'(bus.m1), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
